// File: rtl/timing_nco_mu_gen.sv
// Receive-side timing NCO: modulo-1 decrementing phase accumulator that produces mu and the symbol strobe.
// Optional build macro TIMING_LOOP_PI_EN adds an integral path to the loop filter (proportional only otherwise).
module timing_nco_mu_gen #(
  parameter int NCO_WIDTH = 24,
  parameter int MU_WIDTH  = 10,
  parameter int MU_FRAC   = 9,
  parameter int ERR_WIDTH = 16,
  parameter int SPS_LOG2  = 1,
  parameter int KP_SHIFT  = 4,
  parameter int KI_SHIFT  = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_valid,
  input  logic signed [ERR_WIDTH-1:0] ted_err,
  input  logic                        ted_err_valid,
  input  logic        [NCO_WIDTH-1:0] w_nom,
  input  logic                        freeze,
  output logic        [MU_WIDTH-1:0]  mu,
  output logic                        strobe,
  output logic                        mu_valid,
  output logic        [NCO_WIDTH-1:0] w_out
);

  localparam int IW     = NCO_WIDTH + 2;
  localparam int ERR_SH = NCO_WIDTH - (ERR_WIDTH - 1);
  localparam int SHW    = NCO_WIDTH + SPS_LOG2;

  // Q1.15 error re-expressed as a Q0.NCO_WIDTH fraction in the wide signed domain
  function automatic logic signed [IW-1:0] scale_err(input logic signed [ERR_WIDTH-1:0] e);
    logic signed [IW-1:0] ext;
    ext = IW'(e);
    return ext <<< ERR_SH;
  endfunction

  function automatic logic [MU_WIDTH-1:0] eta_to_mu(input logic [NCO_WIDTH-1:0] e);
    logic [SHW-1:0] sh;
    sh = SHW'(e) << SPS_LOG2;
    if (sh[SHW-1:NCO_WIDTH] != '0) begin
      return {{(MU_WIDTH-MU_FRAC){1'b0}}, {MU_FRAC{1'b1}}};
    end else begin
      return {{(MU_WIDTH-MU_FRAC){1'b0}}, sh[NCO_WIDTH-1 -: MU_FRAC]};
    end
  endfunction

  function automatic logic [NCO_WIDTH-1:0] clamp_w(input logic signed [IW-1:0] s,
                                                   input logic [NCO_WIDTH-1:0] nom);
    logic signed [IW-1:0] nom_x;
    logic signed [IW-1:0] lo;
    logic signed [IW-1:0] hi;
    logic signed [IW-1:0] r;
    nom_x = $signed({2'b00, nom});
    lo    = nom_x - (nom_x >>> 2);
    hi    = nom_x + (nom_x >>> 2);
    if (s < lo) begin
      r = lo;
    end else if (s > hi) begin
      r = hi;
    end else begin
      r = s;
    end
    return r[NCO_WIDTH-1:0];
  endfunction

  logic [NCO_WIDTH-1:0]        eta_q, eta_d;
  logic [NCO_WIDTH-1:0]        w_q, w_d;
  logic signed [ERR_WIDTH-1:0] err_q, err_d;
  logic [MU_WIDTH-1:0]         mu_q, mu_d;
  logic                        strobe_q, strobe_d;
  logic                        mu_valid_q, mu_valid_d;
  logic [NCO_WIDTH-1:0]        diff_s;
  logic                        borrow_s;
  logic signed [IW-1:0]        v_s;
  logic signed [IW-1:0]        w_sum_s;

  assign {borrow_s, diff_s} = {1'b0, eta_q} - {1'b0, w_q};

`ifdef TIMING_LOOP_PI_EN
  localparam logic signed [IW-1:0] INTEG_MAX = IW'(1) <<< (NCO_WIDTH - 2);

  logic signed [IW-1:0] integ_q, integ_d;
  logic signed [IW-1:0] integ_sum_s;

  // Integrator accumulates the fresh error sample; bounded so the loop cannot wind up
  always_comb begin
    integ_sum_s = integ_q + (scale_err(ted_err) >>> KI_SHIFT);
    integ_d     = integ_q;
    if (ted_err_valid && !freeze) begin
      if (integ_sum_s > INTEG_MAX) begin
        integ_d = INTEG_MAX;
      end else if (integ_sum_s < -INTEG_MAX) begin
        integ_d = -INTEG_MAX;
      end else begin
        integ_d = integ_sum_s;
      end
    end else begin
      integ_d = integ_q;
    end
  end

  // Integrator state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
    end else begin
      integ_q <= integ_d;
    end
  end

  assign v_s = (scale_err(err_q) >>> KP_SHIFT) + integ_q;
`else
  assign v_s = scale_err(err_q) >>> KP_SHIFT;
`endif

  assign w_sum_s = $signed({2'b00, w_nom}) + v_s;

  // NCO step, mu capture on underflow, loop-filter and control-word next state
  always_comb begin
    eta_d      = eta_q;
    mu_d       = mu_q;
    strobe_d   = 1'b0;
    mu_valid_d = mu_valid_q;
    err_d      = err_q;
    w_d        = w_q;
    if (sample_valid) begin
      eta_d = diff_s;
      if (borrow_s) begin
        strobe_d   = 1'b1;
        mu_d       = eta_to_mu(eta_q);
        mu_valid_d = 1'b1;
      end else begin
        strobe_d = 1'b0;
      end
    end else begin
      eta_d = eta_q;
    end
    if (ted_err_valid && !freeze) begin
      err_d = ted_err;
    end else begin
      err_d = err_q;
    end
    // the applied W follows err_q, so a new error reaches the NCO one cycle after capture
    if (freeze) begin
      w_d = w_nom;
    end else begin
      w_d = clamp_w(w_sum_s, w_nom);
    end
  end

  // Phase, control word, error and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eta_q      <= {NCO_WIDTH{1'b1}};
      w_q        <= '0;
      err_q      <= '0;
      mu_q       <= '0;
      strobe_q   <= 1'b0;
      mu_valid_q <= 1'b0;
    end else begin
      eta_q      <= eta_d;
      w_q        <= w_d;
      err_q      <= err_d;
      mu_q       <= mu_d;
      strobe_q   <= strobe_d;
      mu_valid_q <= mu_valid_d;
    end
  end

  assign mu       = mu_q;
  assign strobe   = strobe_q;
  assign mu_valid = mu_valid_q;
  assign w_out    = w_q;

endmodule

// File: tb/tb_timing_nco_mu_gen.sv
// Scoreboard bench for timing_nco_mu_gen: a behavioural NCO/loop model pushes expected outputs per cycle.
module tb_timing_nco_mu_gen;

  localparam int WNOM = 32'h0080_0000;
  localparam int MASK = 32'h00FF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic signed [15:0] ted_err;
  logic        ted_err_valid;
  logic [23:0] w_nom;
  logic        freeze;
  logic [9:0]  mu;
  logic        strobe;
  logic        mu_valid;
  logic [23:0] w_out;

  timing_nco_mu_gen dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .ted_err(ted_err),
    .ted_err_valid(ted_err_valid), .w_nom(w_nom), .freeze(freeze),
    .mu(mu), .strobe(strobe), .mu_valid(mu_valid), .w_out(w_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit stb;
    int mu;
    bit mv;
    int w;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int strobe_cnt;

  int eta_m, w_m, err_m, integ_m, mu_m;
  bit mv_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int mu_of(input int e);
    longint t;
    t = longint'(e) * 2;
    if (t >= 64'd16777216) return 511;
    return int'(t / 32768);
  endfunction

  function automatic int model_w();
    int v, s, lo, hi;
    v = (err_m * 512) >>> 4;
`ifdef TIMING_LOOP_PI_EN
    v = v + integ_m;
`endif
    s  = WNOM + v;
    lo = WNOM - WNOM / 4;
    hi = WNOM + WNOM / 4;
    if (s < lo) return lo;
    if (s > hi) return hi;
    return s;
  endfunction

  task automatic model_reset();
    eta_m = MASK; w_m = 0; err_m = 0; integ_m = 0; mu_m = 0; mv_m = 1'b0;
  endtask

  // Drive one cycle, predict the registered outputs, then compare after the edge
  task automatic step(input bit sv, input int err, input bit ev, input bit frz);
    exp_t e, got;
    int nw, inc;
    sample_valid  = sv;
    ted_err       = 16'(err);
    ted_err_valid = ev;
    freeze        = frz;
    e.stb = sv && (eta_m < w_m);
    if (e.stb) begin
      mu_m = mu_of(eta_m);
      mv_m = 1'b1;
    end
    if (sv) eta_m = (eta_m - w_m) & MASK;
    nw = frz ? WNOM : model_w();
    if (ev && !frz) begin
      inc = (err * 512) >>> 10;
      integ_m = integ_m + inc;
      if (integ_m > (1 << 22)) integ_m = 1 << 22;
      if (integ_m < -(1 << 22)) integ_m = -(1 << 22);
      err_m = err;
    end
    w_m  = nw;
    e.mu = mu_m;
    e.mv = mv_m;
    e.w  = w_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check_val("strobe", {31'd0, strobe}, {31'd0, got.stb});
      check_val("mu", {22'd0, mu}, got.mu);
      check_val("mu_valid", {31'd0, mu_valid}, {31'd0, got.mv});
      check_val("w_out", {8'd0, w_out}, got.w);
      if (strobe) strobe_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; ted_err = 16'sd0; ted_err_valid = 1'b0;
    w_nom = 24'h800000; freeze = 1'b0;
    model_reset();
    #12;
    check_val("rst_mu", {22'd0, mu}, 32'd0);
    check_val("rst_strobe", {31'd0, strobe}, 32'd0);
    check_val("rst_mu_valid", {31'd0, mu_valid}, 32'd0);
    check_val("rst_w_out", {8'd0, w_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal rate, zero error, continuous samples
    strobe_cnt = 0;
    for (int i = 0; i < 24; i++) step(1'b1, 0, 1'b0, 1'b0);
    check_val("nom_strobes", strobe_cnt, 32'd11);
    check_val("nom_mu", {22'd0, mu}, 32'h1FF);

    // One valid sample in three: strobes only on every second valid sample
    strobe_cnt = 0;
    for (int i = 0; i < 36; i++) step(i % 3 == 0, 0, 1'b0, 1'b0);
    check_val("sparse_strobes", strobe_cnt, 32'd6);

    // Max positive error held
    for (int i = 0; i < 160; i++) step(1'b1, 32'h7FFF, 1'b1, 1'b0);
    // Freeze and release
    for (int i = 0; i < 5; i++) step(1'b1, 32'h7FFF, 1'b1, 1'b1);
    check_val("freeze_w", {8'd0, w_out}, WNOM);
    for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0, 1'b0);
    // Max negative error held
    for (int i = 0; i < 160; i++) step(1'b1, -32768, 1'b1, 1'b0);
    check_val("neg_floor", {31'd0, (w_out >= 24'h600000)}, 32'd1);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_mu", {22'd0, mu}, 32'd0);
    check_val("mid_rst_strobe", {31'd0, strobe}, 32'd0);
    check_val("mid_rst_mu_valid", {31'd0, mu_valid}, 32'd0);
    check_val("mid_rst_w_out", {8'd0, w_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 0, 1'b0, 1'b0);

    // Random mix of valids, errors, error pulses and freeze
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 65535);
      step($urandom_range(0, 3) != 0, int'($signed(16'(r))), $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
